octant_rom_arbiter: RTL and testbench

Shares the dual-read-port octant ROM between NUM_REQ octree-traversal requesters, such as per-ray node fetch units. Each cycle it grants up to two requesters round-robin, one per ROM port, and drives the ROM addresses and read enables. It captures the ROM data one cycle later and returns it to each requester through a registered valid/ready response buffer. It sits between the traversal units and the octant ROM.

---
 rtl/octree_pkg.sv | 24 ++
 rtl/octant_rom_rr_picker.sv | 46 ++++
 rtl/octant_rom_arbiter.sv | 148 ++++++++++++++
 tb/tb_octant_rom_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/octree_pkg.sv
// rtl/octree_pkg.sv - shared types and constants for the octant ROM arbiter
package octree_pkg;

   localparam int ROM_DEPTH_DEFAULT = 38;

   // Requester ids are sized for the largest supported NUM_REQ (16) so one type serves every build
   localparam int MAX_REQ      = 16;
   localparam int REQ_ID_WIDTH = $clog2(MAX_REQ);

   typedef logic [REQ_ID_WIDTH-1:0] req_id_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      INFLIGHT = 2'd1,
      RESP     = 2'd2
   } req_state_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
      logic    err;
   } port_track_t;

endpackage

// File: rtl/octant_rom_rr_picker.sv
// rtl/octant_rom_rr_picker.sv - circular two-winner priority picker starting at rr_ptr
module octant_rom_rr_picker
   import octree_pkg::*;
#(
   parameter int NUM_REQ = 4
)
(
   input  logic [NUM_REQ-1:0] eligible,
   input  req_id_t            rr_ptr,
   output logic               grant1_valid,
   output req_id_t            grant1_id,
   output logic               grant2_valid,
   output req_id_t            grant2_id,
   output req_id_t            next_rr_ptr
);

   logic [2*NUM_REQ-1:0] doubled;
   logic [NUM_REQ-1:0]   rotated;

   // Rotate so bit 0 is the requester at rr_ptr; the doubled copy supplies the wrap-around
   assign doubled = {eligible, eligible} >> rr_ptr;
   assign rotated = doubled[NUM_REQ-1:0];

   // First eligible in rotated order wins port 1, the next one wins port 2
   always_comb begin
      grant1_valid = 1'b0;
      grant1_id    = '0;
      grant2_valid = 1'b0;
      grant2_id    = '0;
      next_rr_ptr  = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (rotated[k]) begin
            if (!grant1_valid) begin
               grant1_valid = 1'b1;
               grant1_id    = req_id_t'((int'(rr_ptr) + k) % NUM_REQ);
               next_rr_ptr  = req_id_t'((int'(rr_ptr) + k + 1) % NUM_REQ);
            end else if (!grant2_valid) begin
               grant2_valid = 1'b1;
               grant2_id    = req_id_t'((int'(rr_ptr) + k) % NUM_REQ);
               next_rr_ptr  = req_id_t'((int'(rr_ptr) + k + 1) % NUM_REQ);
            end
         end
      end
   end

endmodule

// File: rtl/octant_rom_arbiter.sv
// rtl/octant_rom_arbiter.sv - shares the dual-port octant ROM between NUM_REQ requesters
module octant_rom_arbiter
   import octree_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int ROM_DEPTH     = ROM_DEPTH_DEFAULT
)
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]               rsp_valid,
   input  logic [NUM_REQ-1:0]               rsp_ready,
   output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data,
   output logic [NUM_REQ-1:0]               rsp_err,
   output logic [ADDRESS_WIDTH-1:0]         rom_addr1,
   output logic [ADDRESS_WIDTH-1:0]         rom_addr2,
   output logic                             rom_ren1,
   output logic                             rom_ren2,
   input  logic [DATA_WIDTH-1:0]            rom_dout1,
   input  logic [DATA_WIDTH-1:0]            rom_dout2
);

   req_state_t               state      [NUM_REQ];
   req_state_t               state_next [NUM_REQ];
   logic [DATA_WIDTH-1:0]    data_q     [NUM_REQ];
   logic [NUM_REQ-1:0]       err_q;
   logic [NUM_REQ-1:0]       eligible;
   req_id_t                  rr_ptr;
   req_id_t                  rr_ptr_next;
   logic                     g1_valid, g2_valid;
   req_id_t                  g1_id, g2_id;
   logic [ADDRESS_WIDTH-1:0] addr1, addr2;
   logic                     oor1, oor2;
   port_track_t              track1, track2;

   // Only idle requesters may compete; reset forces every grant and ROM enable low
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = rst_n && req_valid[i] && (state[i] == IDLE);
   end

   octant_rom_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .eligible     (eligible),
      .rr_ptr       (rr_ptr),
      .grant1_valid (g1_valid),
      .grant1_id    (g1_id),
      .grant2_valid (g2_valid),
      .grant2_id    (g2_id),
      .next_rr_ptr  (rr_ptr_next)
   );

   // Steer granted addresses to the ports; out-of-range reads take the slot but never touch the ROM
   always_comb begin
      addr1     = '0;
      addr2     = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (g1_valid && g1_id == req_id_t'(i)) begin
            addr1        = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            req_ready[i] = 1'b1;
         end
         if (g2_valid && g2_id == req_id_t'(i)) begin
            addr2        = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            req_ready[i] = 1'b1;
         end
      end
      oor1      = addr1 >= ADDRESS_WIDTH'(ROM_DEPTH);
      oor2      = addr2 >= ADDRESS_WIDTH'(ROM_DEPTH);
      rom_ren1  = g1_valid && !oor1;
      rom_ren2  = g2_valid && !oor2;
      rom_addr1 = rom_ren1 ? addr1 : '0;
      rom_addr2 = rom_ren2 ? addr2 : '0;
   end

   // Remember who owns each port's data next cycle, and advance the round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         track1 <= '0;
         track2 <= '0;
         rr_ptr <= '0;
      end else begin
         track1 <= '{valid: g1_valid, id: g1_id, err: g1_valid && oor1};
         track2 <= '{valid: g2_valid, id: g2_id, err: g2_valid && oor2};
         rr_ptr <= rr_ptr_next;
      end
   end

   // Per-requester state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) state[i] <= IDLE;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) state[i] <= state_next[i];
      end
   end

   // Per-requester next state: handshake, fixed one-cycle ROM wait, then hold until accepted
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         state_next[i] = state[i];
         case (state[i])
            IDLE:     if (req_ready[i]) state_next[i] = INFLIGHT;
            INFLIGHT: state_next[i] = RESP;
            RESP:     if (rsp_ready[i]) state_next[i] = IDLE;
            default:  state_next[i] = IDLE;
         endcase
      end
   end

   // Load the response buffer from whichever port carried this requester's read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) data_q[i] <= '0;
         err_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (state[i] == INFLIGHT) begin
               if (track1.valid && track1.id == req_id_t'(i)) begin
                  data_q[i] <= track1.err ? '0 : rom_dout1;
                  err_q[i]  <= track1.err;
               end else if (track2.valid && track2.id == req_id_t'(i)) begin
                  data_q[i] <= track2.err ? '0 : rom_dout2;
                  err_q[i]  <= track2.err;
               end
            end
         end
      end
   end

   // Flatten the response buffers onto the output buses
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i]                        = (state[i] == RESP);
         rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
      end
   end

   assign rsp_err = err_q;

endmodule

// File: tb/tb_octant_rom_arbiter.sv
// tb/tb_octant_rom_arbiter.sv - scoreboard bench for octant_rom_arbiter
module tb_octant_rom_arbiter;
   localparam int NR    = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 38;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] rsp_data;
   logic [AW-1:0]   rom_addr1, rom_addr2;
   logic            rom_ren1, rom_ren2;
   logic [DW-1:0]   rom_dout1 = '0;
   logic [DW-1:0]   rom_dout2 = '0;

   exp_t            exp_q [NR][$];
   exp_t            mon_e;
   logic [AW-1:0]   mon_a;
   int              vectors = 0;
   int              miscompares = 0;

   octant_rom_arbiter #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ROM_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rom_addr1 (rom_addr1),
      .rom_addr2 (rom_addr2),
      .rom_ren1  (rom_ren1),
      .rom_ren2  (rom_ren2),
      .rom_dout1 (rom_dout1),
      .rom_dout2 (rom_dout2)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      return 32'h0C7A_0000 + a * 32'h0000_0101;
   endfunction

   // ROM model: both douts update one cycle after either enable
   always @(posedge clk) begin
      if (rom_ren1 || rom_ren2) begin
         rom_dout1 <= rom_word(rom_addr1);
         rom_dout2 <= rom_word(rom_addr2);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   // Monitor: pop and compare on every response handshake, push expectations on every request handshake
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NR; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               vectors++;
               if (exp_q[i].size() == 0) begin
                  miscompares++;
                  $display("FAIL rsp_unexpected[%0d]: got data %0h err %0b, expected no response",
                           i, rsp_data[i*DW +: DW], rsp_err[i]);
               end else begin
                  mon_e = exp_q[i].pop_front();
                  if (rsp_data[i*DW +: DW] !== mon_e.data || rsp_err[i] !== mon_e.err) begin
                     miscompares++;
                     $display("FAIL rsp[%0d]: got data %0h err %0b expected data %0h err %0b",
                              i, rsp_data[i*DW +: DW], rsp_err[i], mon_e.data, mon_e.err);
                  end
               end
            end
            if (req_valid[i] && req_ready[i]) begin
               mon_a = req_addr[i*AW +: AW];
               if (mon_a >= AW'(DEPTH)) begin
                  mon_e.data = '0;
                  mon_e.err  = 1'b1;
               end else begin
                  mon_e.data = rom_word(mon_a);
                  mon_e.err  = 1'b0;
               end
               exp_q[i].push_back(mon_e);
            end
         end
      end
   end

   initial begin
      req_valid = '0;
      req_addr  = '0;
      rsp_ready = '1;

      // Reset state, with every requester asking
      repeat (2) @(posedge clk);
      #1;
      req_valid = '1;
      #1;
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_err", rsp_err, 0);
      check("reset_rsp_data_nonzero", |rsp_data, 0);
      check("reset_rom_ren1", rom_ren1, 0);
      check("reset_rom_ren2", rom_ren2, 0);
      req_valid = '0;
      rst_n = 1'b1;

      // Four simultaneous requests: {0,1} then {2,3}
      set_addr(0, 1); set_addr(1, 2); set_addr(2, 3); set_addr(3, 4);
      req_valid = 4'b1111;
      #1;
      check("four_t0_ready", req_ready, 4'b0011);
      check("four_t0_ren", {rom_ren1, rom_ren2}, 2'b11);
      check("four_t0_addr1", rom_addr1, 1);
      check("four_t0_addr2", rom_addr2, 2);
      step();
      req_valid = 4'b1100;
      #1;
      check("four_t1_ready", req_ready, 4'b1100);
      check("four_t1_addr1", rom_addr1, 3);
      check("four_t1_addr2", rom_addr2, 4);
      step();
      req_valid = '0;
      #1;
      check("four_t2_rsp_valid", rsp_valid, 4'b0011);
      step();
      check("four_t3_rsp_valid", rsp_valid, 4'b1100);
      step();
      check("four_t4_rsp_valid", rsp_valid, 4'b0000);

      // Pointer back at 0: requester 0 must take port 1 ahead of 3
      set_addr(0, 7); set_addr(3, 8);
      req_valid = 4'b1001;
      #1;
      check("ptr0_ready", req_ready, 4'b1001);
      check("ptr0_addr1", rom_addr1, 7);
      check("ptr0_addr2", rom_addr2, 8);
      step();
      req_valid = '0;
      step();
      step();

      // Single request, exact latency
      set_addr(0, 5);
      req_valid = 4'b0001;
      #1;
      check("single_ready", req_ready, 4'b0001);
      check("single_ren1", rom_ren1, 1);
      check("single_addr1", rom_addr1, 5);
      check("single_ren2", rom_ren2, 0);
      check("single_addr2", rom_addr2, 0);
      step();
      req_valid = '0;
      #1;
      check("single_t1_rsp_valid", rsp_valid, 0);
      step();
      check("single_t2_rsp_valid", rsp_valid, 4'b0001);
      check("single_t2_data", rsp_data[0 +: DW], rom_word(5));
      check("single_t2_err", rsp_err[0], 0);
      step();

      // Fairness: 0 and 1 continuous, 2 joins one cycle later (pointer at 1)
      set_addr(0, 10); set_addr(1, 11); set_addr(2, 12);
      req_valid = 4'b0011;
      #1;
      check("fair_t0_ready", req_ready, 4'b0011);
      check("fair_t0_addr1", rom_addr1, 11);
      check("fair_t0_addr2", rom_addr2, 10);
      step();
      req_valid = 4'b0111;
      #1;
      check("fair_t1_ready", req_ready, 4'b0100);
      check("fair_t1_addr1", rom_addr1, 12);
      step();
      check("fair_t2_ready", req_ready, 4'b0000);
      step();
      check("fair_t3_ready", req_ready, 4'b0011);
      check("fair_t3_addr1", rom_addr1, 10);
      check("fair_t3_addr2", rom_addr2, 11);
      step();
      req_valid = '0;
      step();
      step();

      // Backpressure on requester 1 for 5 cycles; re-request waits for the accept
      set_addr(1, 20);
      req_valid = 4'b0010;
      rsp_ready = 4'b1101;
      #1;
      check("bp_t0_ready", req_ready, 4'b0010);
      step();
      check("bp_t1_ready", req_ready, 4'b0000);
      step();
      for (int c = 0; c < 5; c++) begin
         check("bp_hold_valid", rsp_valid[1], 1);
         check("bp_hold_data", rsp_data[DW +: DW], rom_word(20));
         check("bp_hold_not_granted", req_ready[1], 0);
         step();
      end
      rsp_ready = '1;
      set_addr(1, 21);
      #1;
      check("bp_accept_valid", rsp_valid[1], 1);
      check("bp_accept_not_granted", req_ready[1], 0);
      step();
      check("bp_regrant_ready", req_ready[1], 1);
      check("bp_regrant_addr1", rom_addr1, 21);
      step();
      req_valid = '0;
      step();
      step();

      // Out-of-range on requester 3 next to an in-range read on requester 2
      set_addr(2, 6); set_addr(3, 38);
      req_valid = 4'b1100;
      #1;
      check("oor_ready", req_ready, 4'b1100);
      check("oor_ren1", rom_ren1, 1);
      check("oor_addr1", rom_addr1, 6);
      check("oor_ren2", rom_ren2, 0);
      check("oor_addr2", rom_addr2, 0);
      step();
      req_valid = '0;
      step();
      check("oor_rsp_valid", rsp_valid, 4'b1100);
      check("oor_rsp_err", rsp_err, 4'b1000);
      check("oor_rsp_data3", rsp_data[3*DW +: DW], 0);
      check("oor_rsp_data2", rsp_data[2*DW +: DW], rom_word(6));
      step();

      // Last valid address is still read from the ROM
      set_addr(0, 37);
      req_valid = 4'b0001;
      #1;
      check("edge37_ren1", rom_ren1, 1);
      check("edge37_addr1", rom_addr1, 37);
      step();
      req_valid = '0;
      step();
      step();

      // Reset one cycle after a handshake (pointer at 1 before this grant)
      set_addr(2, 9);
      req_valid = 4'b0100;
      #1;
      check("rst_pre_ready", req_ready, 4'b0100);
      step();
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NR; i++) exp_q[i].delete();
      check("rst_async_rsp_valid", rsp_valid, 0);
      check("rst_async_ren", {rom_ren1, rom_ren2}, 2'b00);
      step();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("rst_no_rsp", rsp_valid, 0);
      end
      set_addr(0, 13); set_addr(3, 14);
      req_valid = 4'b1001;
      #1;
      check("rst_ptr_addr1", rom_addr1, 13);
      check("rst_ptr_addr2", rom_addr2, 14);
      step();
      req_valid = '0;
      step();
      check("rst_after_rsp_valid", rsp_valid, 4'b1001);
      step();
      step();

      for (int i = 0; i < NR; i++)
         check("queue_drained", exp_q[i].size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
